// File: rtl/vga_pkg.sv
// Shared VGA geometry and framebuffer constants for the timing controller and pixel pipeline.
package vga_pkg;

  localparam int unsigned H_VISIBLE   = 640;
  localparam int unsigned V_VISIBLE   = 480;
  localparam int unsigned H_TOTAL     = 800;
  localparam int unsigned V_TOTAL     = 525;
  localparam int unsigned SCALE_SHIFT = 2;
  localparam int unsigned FB_WIDTH    = H_VISIBLE >> SCALE_SHIFT;
  localparam int unsigned ADDR_WIDTH  = 15;

  localparam int unsigned COORD_WIDTH     = $clog2((H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL);
  localparam int unsigned SUM_WIDTH       = ADDR_WIDTH + 1;
  localparam int unsigned FB_SHIFT_HI     = 7;
  localparam int unsigned FB_SHIFT_LO     = 5;
  localparam int unsigned RGB_WIDTH       = 3;
  localparam int unsigned FRAME_CNT_WIDTH = 8;
  localparam int unsigned SIDEBAND_DEPTH  = 3;

  // Per-pixel control carried alongside the RAM read latency.
  typedef struct packed {
    logic visible;
    logic hs;
    logic vs;
  } sideband_t;

  localparam int unsigned SIDEBAND_WIDTH = $bits(sideband_t);
  localparam sideband_t   SIDEBAND_RESET = '{visible: 1'b0, hs: 1'b1, vs: 1'b1};

  // row * FB_WIDTH + col built from two shifts so no multiplier is inferred.
  function automatic logic [SUM_WIDTH-1:0] fb_index(input logic [COORD_WIDTH-1:0] row_s,
                                                    input logic [COORD_WIDTH-1:0] col_s);
    return (SUM_WIDTH'(row_s) << FB_SHIFT_HI) + (SUM_WIDTH'(row_s) << FB_SHIFT_LO) + SUM_WIDTH'(col_s);
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Async-reset shift register; every stage is exposed so callers can tap intermediate delays.
module vga_delay_line #(
  parameter int unsigned             WIDTH       = 1,
  parameter int unsigned             DEPTH       = 1,
  parameter logic [WIDTH-1:0]        RESET_VALUE = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [WIDTH-1:0]             din,
  output logic [DEPTH-1:0][WIDTH-1:0]  taps
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        taps[i] <= RESET_VALUE;
      end
    end else begin
      taps[0] <= din;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        taps[i] <= taps[i-1];
      end
    end
  end

endmodule

// File: rtl/vga_pixel_pipeline.sv
// Pixel stage after the VGA timing controller: framebuffer addressing, colour masking,
// sync realignment to the 3-cycle colour path, and frame start/count tracking.
module vga_pixel_pipeline
  import vga_pkg::*;
(
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic [COORD_WIDTH-1:0]     iColumn,
  input  logic [COORD_WIDTH-1:0]     iRow,
  input  logic                       iHS,
  input  logic                       iVS,
  output logic [ADDR_WIDTH-1:0]      oVmemAddress,
  input  logic [RGB_WIDTH-1:0]       iVmemData,
  output logic                       oRed,
  output logic                       oGreen,
  output logic                       oBlue,
  output logic                       oHS,
  output logic                       oVS,
  output logic                       oFrameStart,
  output logic [FRAME_CNT_WIDTH-1:0] oFrameCount
);

  if (FB_WIDTH != ((2 ** FB_SHIFT_HI) + (2 ** FB_SHIFT_LO))) begin : g_fb_width_check
    $error("FB_WIDTH does not match the shift-add address decomposition");
  end

  logic                                          visible_c;
  logic [COORD_WIDTH-1:0]                        col_scaled_c;
  logic [COORD_WIDTH-1:0]                        row_scaled_c;
  logic [SUM_WIDTH-1:0]                          addr_sum_c;
  logic                                          frame_edge_c;
  sideband_t                                     sb_in_c;
  sideband_t                                     sb_d2;
  sideband_t                                     sb_d3;
  logic [SIDEBAND_DEPTH-1:0][SIDEBAND_WIDTH-1:0] sb_taps;
  logic                                          vs_prev;
  logic                                          armed;
  logic                                          unused_ok;

  // Address and visibility come straight from the controller's coordinates.
  always_comb begin
    visible_c    = (iColumn < COORD_WIDTH'(H_VISIBLE)) && (iRow < COORD_WIDTH'(V_VISIBLE));
    col_scaled_c = iColumn >> SCALE_SHIFT;
    row_scaled_c = iRow >> SCALE_SHIFT;
    addr_sum_c   = fb_index(row_scaled_c, col_scaled_c);
    sb_in_c      = '{visible: visible_c, hs: iHS, vs: iVS};
  end

  vga_delay_line #(
    .WIDTH       (SIDEBAND_WIDTH),
    .DEPTH       (SIDEBAND_DEPTH),
    .RESET_VALUE (SIDEBAND_WIDTH'(SIDEBAND_RESET))
  ) u_sideband (
    .clk  (Clock),
    .rst  (Reset),
    .din  (sb_in_c),
    .taps (sb_taps)
  );

  // Visible is consumed one stage early because the colour register adds the last delay.
  assign sb_d2 = sideband_t'(sb_taps[1]);
  assign sb_d3 = sideband_t'(sb_taps[SIDEBAND_DEPTH-1]);
  assign oHS   = sb_d3.hs;
  assign oVS   = sb_d3.vs;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      oVmemAddress <= '0;
      oRed         <= 1'b0;
      oGreen       <= 1'b0;
      oBlue        <= 1'b0;
    end else begin
      oVmemAddress <= addr_sum_c[ADDR_WIDTH-1:0];
      oRed         <= iVmemData[2] & sb_d2.visible;
      oGreen       <= iVmemData[1] & sb_d2.visible;
      oBlue        <= iVmemData[0] & sb_d2.visible;
    end
  end

  // armed suppresses the edge that vs_prev's reset value of 1 would fake on the first clock.
  assign frame_edge_c = armed & vs_prev & ~iVS;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      vs_prev     <= 1'b1;
      armed       <= 1'b0;
      oFrameStart <= 1'b0;
      oFrameCount <= '0;
    end else begin
      vs_prev     <= iVS;
      armed       <= 1'b1;
      oFrameStart <= frame_edge_c;
      if (frame_edge_c) begin
        oFrameCount <= oFrameCount + FRAME_CNT_WIDTH'(1);
      end
    end
  end

  assign unused_ok = &{1'b0, sb_taps[0], sb_d2.hs, sb_d2.vs, sb_d3.visible, addr_sum_c[ADDR_WIDTH]};

endmodule

// File: tb/tb_vga_pixel_pipeline.sv
// Randomized and directed bench for vga_pixel_pipeline against a coordinate-level reference model.
`timescale 1ns/1ps
module tb_vga_pixel_pipeline;
  import vga_pkg::*;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [9:0]  iColumn;
  logic [9:0]  iRow;
  logic        iHS;
  logic        iVS;
  logic [14:0] oVmemAddress;
  logic [2:0]  iVmemData;
  logic        oRed, oGreen, oBlue, oHS, oVS, oFrameStart;
  logic [7:0]  oFrameCount;

  vga_pixel_pipeline dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .iColumn      (iColumn),
    .iRow         (iRow),
    .iHS          (iHS),
    .iVS          (iVS),
    .oVmemAddress (oVmemAddress),
    .iVmemData    (iVmemData),
    .oRed         (oRed),
    .oGreen       (oGreen),
    .oBlue        (oBlue),
    .oHS          (oHS),
    .oVS          (oVS),
    .oFrameStart  (oFrameStart),
    .oFrameCount  (oFrameCount)
  );

  always #20 Clock = ~Clock;

  // Synchronous-read video RAM
  logic [2:0] mem [32768];
  always @(posedge Clock) iVmemData <= mem[oVmemAddress];

  typedef struct {
    int unsigned rgb;
    bit          hs;
    bit          vs;
  } px_t;

  px_t         hist[$];
  int          errors = 0;
  int          checks = 0;
  int unsigned fcnt_exp = 0;
  int          pulses;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_addr"}, 32'(oVmemAddress), 32'd0);
    check_eq({tag, "_rgb"}, 32'({oRed, oGreen, oBlue}), 32'd0);
    check_eq({tag, "_hs"}, 32'(oHS), 32'd1);
    check_eq({tag, "_vs"}, 32'(oVS), 32'd1);
    check_eq({tag, "_fs"}, 32'(oFrameStart), 32'd0);
    check_eq({tag, "_fcnt"}, 32'(oFrameCount), 32'd0);
  endtask

  // One pixel clock: apply coordinates, advance one edge, compare every output to the model.
  task automatic drive(input int col, input int row, input bit hs, input bit vs);
    px_t         e;
    px_t         old;
    int unsigned addr;
    bit          vis;
    bit          fs;
    iColumn = 10'(col);
    iRow    = 10'(row);
    iHS     = hs;
    iVS     = vs;
    addr    = 32'((row / 4) * 160 + (col / 4));
    vis     = (col < 640) && (row < 480);
    e.rgb   = vis ? 32'(mem[addr]) : 0;
    e.hs    = hs;
    e.vs    = vs;
    fs      = (hist.size() > 0) && hist[hist.size()-1].vs && !vs;
    hist.push_back(e);
    if (hist.size() > 3) void'(hist.pop_front());
    @(posedge Clock);
    #1;
    if (fs) fcnt_exp = (fcnt_exp + 1) % 256;
    if (hist.size() == 3) old = hist[0];
    else begin
      old.rgb = 0;
      old.hs  = 1'b1;
      old.vs  = 1'b1;
    end
    if (oFrameStart === 1'b1) pulses++;
    check_eq("addr", 32'(oVmemAddress), addr);
    check_eq("rgb", 32'({oRed, oGreen, oBlue}), old.rgb);
    check_eq("hs", 32'(oHS), 32'(old.hs));
    check_eq("vs", 32'(oVS), 32'(old.vs));
    check_eq("frame_start", 32'(oFrameStart), 32'(fs));
    check_eq("frame_count", 32'(oFrameCount), fcnt_exp);
  endtask

  initial begin
    int start_cnt;
    for (int i = 0; i < 32768; i++) mem[i] = 3'($urandom);
    Reset   = 1'b1;
    iColumn = 10'd0;
    iRow    = 10'd0;
    iHS     = 1'b1;
    iVS     = 1'b1;
    #5;
    check_reset_values("por");
    @(negedge Clock);
    Reset = 1'b0;
    hist.delete();
    fcnt_exp = 0;
    pulses   = 0;

    // Column sweep on row 0 with a known colour in the first two cells
    mem[0] = 3'b101;
    mem[1] = 3'b101;
    for (int c = 0; c < 8; c++) drive(c, 0, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) drive(8, 0, 1'b1, 1'b1);

    // Visible/blank boundaries, blanked cells backed by all-ones data
    mem[19199] = 3'($urandom_range(1, 7));
    mem[19200] = 3'b111;
    mem[19359] = 3'b111;
    mem[19360] = 3'b111;
    drive(639, 479, 1'b1, 1'b1);
    drive(640, 479, 1'b1, 1'b1);
    drive(639, 480, 1'b1, 1'b1);
    drive(640, 480, 1'b1, 1'b1);
    drive(639, 479, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) drive(0, 0, 1'b1, 1'b1);

    // 96-cycle HS pulse starting at column 656
    for (int c = 600; c < 800; c++) drive(c, 100, !(c >= 656 && c < 752), 1'b1);
    // 96-cycle VS pulse
    for (int k = 0; k < 120; k++) drive(k, 490, 1'b1, !(k >= 10 && k < 106));

    // Raster across the bottom visible/blank row boundary
    for (int r = 476; r < 484; r++)
      for (int c = 0; c < 800; c++) drive(c, r, !(c >= 656 && c < 752), 1'b1);

    // Random coordinates and syncs
    for (int k = 0; k < 15000; k++)
      drive($urandom_range(0, 799), $urandom_range(0, 524),
            $urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0);

    // 256 VS falling edges wrap the frame counter back to its start value
    drive(0, 0, 1'b1, 1'b1);
    start_cnt = int'(fcnt_exp);
    pulses = 0;
    for (int k = 0; k < 256; k++) begin
      drive(k, 500, 1'b1, 1'b1);
      drive(k, 501, 1'b1, 1'b0);
    end
    check_eq("fcnt_wrap", 32'(oFrameCount), 32'(start_cnt));
    check_eq("fs_pulses", 32'(pulses), 32'd256);

    // Reset mid-line with VS held low through release
    for (int c = 300; c < 310; c++) drive(c, 200, 1'b1, 1'b1);
    iVS = 1'b0;
    #3;
    Reset = 1'b1;
    #1;
    check_reset_values("midline");
    repeat (3) @(posedge Clock);
    #1;
    check_reset_values("held");
    @(negedge Clock);
    Reset = 1'b0;
    hist.delete();
    fcnt_exp = 0;
    pulses = 0;
    for (int c = 310; c < 320; c++) drive(c, 200, 1'b1, 1'b0);
    check_eq("no_fs_after_release", 32'(pulses), 32'd0);
    for (int c = 320; c < 330; c++) drive(c, 201, 1'b1, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_pixel_pipeline.md
# vga_pixel_pipeline

Downstream stage of the VGA timing controller. Takes the controller's current column/row and raw sync signals, generates the video-memory read address for a 160x120 3-bit framebuffer (4x pixel replication onto 640x480), and returns registered RGB with HS/VS re-aligned to the pixel data. It drives the external VGA pins directly.

## Interface
- H_VISIBLE, 640: visible columns; columns >= H_VISIBLE are blanked.
- V_VISIBLE, 480: visible rows; rows >= V_VISIBLE are blanked.
- SCALE_SHIFT, 2: log2 pixel replication factor in both axes.
- FB_WIDTH, 160: framebuffer width in pixels (H_VISIBLE >> SCALE_SHIFT).
- ADDR_WIDTH, 15: video-memory address width (covers 160*120 = 19200 words).
- Clock  input  1  25 MHz pixel clock, all logic on rising edge.
- Reset  input  1  asynchronous, active-high; clears all state immediately.
- iColumn  input  10  current column from timing controller, 0..799.
- iRow  input  10  current row from timing controller, 0..524.
- iHS  input  1  raw horizontal sync, active-low, aligned with iColumn.
- iVS  input  1  raw vertical sync, active-low, aligned with iRow.
- oVmemAddress  output  ADDR_WIDTH  synchronous-read address to video RAM.
- iVmemData  input  3  RAM read data {R,G,B}, valid 1 cycle after address is presented.
- oRed, oGreen, oBlue  output  1 each  pixel colour, 0 during blanking.
- oHS, oVS  output  1 each  syncs delayed to match colour.
- oFrameStart  output  1  one-cycle pulse on each iVS falling edge, unaligned (raw input path).
- oFrameCount  output  8  frames since reset, wraps 255 -> 0.

## Operation
- Stage 1 (edge n+1): register visible = (iColumn < H_VISIBLE) && (iRow < V_VISIBLE); register oVmemAddress = (iRow >> SCALE_SHIFT) * FB_WIDTH + (iColumn >> SCALE_SHIFT).
- Multiply by FB_WIDTH implemented as shift-add ((r<<7)+(r<<5) for 160); no DSP multiplier. Intermediate sum ADDR_WIDTH+1 bits, truncated to ADDR_WIDTH.
- When not visible, address is still computed from inputs (don't-care to RAM); colour masked by the delayed visible flag, not by address.
- Stage 2 (edge n+2): RAM presents iVmemData for stage-1 address; visible, HS, VS carried in pipeline.
- Stage 3 (edge n+3): oRed/oGreen/oBlue = iVmemData[2]/[1]/[0] AND visible_d2; oHS/oVS from 3-deep delay.
- Frame tracking: iVS registered once; falling edge (prev 1, now 0) -> oFrameStart = 1 for one cycle, oFrameCount increments same edge.
- No handshake; pipeline advances every cycle, no stall.

## Timing
- Input-to-colour latency 3 cycles; input-to-address latency 1 cycle; HS/VS latency exactly 3 cycles so sync and colour stay aligned.
- Reset values: oVmemAddress 0, oRed/oGreen/oBlue 0, oHS 1, oVS 1 (inactive), oFrameStart 0, oFrameCount 0; all delay stages to visible=0, HS=1, VS=1, iVS-prev=1.
- Reset mid-line: outputs go to reset values asynchronously; after release, first valid colour 3 cycles later; no spurious oFrameStart on release, even if iVS is 0 (prev reset to 1 would produce one — therefore prev register resets to 1 and the first post-reset cycle is masked by a one-bit armed flag set on first clock after reset).
- Boundary: column 639 visible, 640 blanked; row 479 visible, 480 blanked; max address 119*160+159 = 19199.
- oFrameCount wrap 255 -> 0 with oFrameStart still pulsing.

## Structure
- Package vga_pkg: H_VISIBLE, V_VISIBLE, H_TOTAL 800, V_TOTAL 525, SCALE_SHIFT, FB_WIDTH, ADDR_WIDTH, shared with the timing controller.
- Sub-module vga_delay_line (parameters WIDTH, DEPTH, RESET_VALUE): async-reset shift register used for the {visible, HS, VS} sideband, instantiated with WIDTH 3, DEPTH 3, RESET_VALUE 3'b011.

## Test plan
- Reset asserted mid-frame -> all outputs at reset values same cycle, oHS=oVS=1, oFrameCount=0; no oFrameStart after release with iVS held 0.
- Sweep column 0..7, row 0 -> addresses 0,0,0,0,1,1,1,1 one cycle later; with RAM model returning 3'b101 -> oRed=1,oGreen=0,oBlue=1 three cycles after inputs.
- Column 639 row 479 -> oVmemAddress 19199; column 640 or row 480 with RAM data 3'b111 -> RGB 0.
- iHS pulse low for 96 cycles at column 656 -> oHS low for exactly 96 cycles starting 3 cycles later; same check for iVS.
- 256 iVS falling edges -> 256 single-cycle oFrameStart pulses, oFrameCount back to 0.
- Full 800x525 frame against reference model -> every colour, address and sync cycle-exact.
